// File: rtl/tile_map_renderer.sv
// Tile map renderer: walks a MAP_W x MAP_H grid, resolves map/overlay tile ids and
// blits each TILE_PX x TILE_PX tile from resource ROM into the frame buffer.
module tile_map_renderer #(
    parameter int              MAP_W      = 13,
    parameter int              MAP_H      = 13,
    parameter int              TILE_PX    = 32,
    parameter int              FB_W       = 640,
    parameter int              N_OVL      = 4,
    parameter int              CW         = 4,
    parameter int              ID_W       = 16,
    parameter int              ADDR_W     = 19,
    parameter int              PIX_W      = 16,
    parameter int              KEY_EN     = 0,
    parameter logic [PIX_W-1:0] KEY_COL   = 16'h0000,
    parameter int              CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [N_OVL-1:0]      ovl_en,
    input  logic [N_OVL*CW-1:0]   ovl_x,
    input  logic [N_OVL*CW-1:0]   ovl_y,
    input  logic [N_OVL*ID_W-1:0] ovl_id,
    output logic [ADDR_W-1:0]     map_addr,
    input  logic [ID_W-1:0]       map_data,
    output logic [ADDR_W-1:0]     res_addr,
    input  logic [PIX_W-1:0]      res_data,
    output logic [ADDR_W-1:0]     dst_addr,
    output logic [PIX_W-1:0]      dst_data,
    output logic                  dst_wr
);

    localparam int PXW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam logic [ADDR_W-1:0] L_MAP_W = ADDR_W'(MAP_W);
    localparam logic [ADDR_W-1:0] L_TILE  = ADDR_W'(TILE_PX);
    localparam logic [ADDR_W-1:0] L_AREA  = ADDR_W'(TILE_PX * TILE_PX);
    localparam logic [ADDR_W-1:0] L_FB_W  = ADDR_W'(FB_W);
    localparam logic [PXW-1:0]    PX_LAST = PXW'(TILE_PX - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RESOLVE, S_PIX, S_DONE} state_t;

    state_t r_state, w_next;

    logic [CW-1:0]         r_gx, r_gy;
    logic [PXW-1:0]        r_px, r_py;
    logic [ID_W-1:0]       r_id;
    logic                  r_hit;
    logic [N_OVL-1:0]      r_sh_en;
    logic [N_OVL*CW-1:0]   r_sh_x, r_sh_y;
    logic [N_OVL*ID_W-1:0] r_sh_id;
    logic                  r_vld_p1, r_hit_p1;
    logic [ADDR_W-1:0]     r_dst_addr_p1;

    logic                  w_last_px, w_last_col, w_last_row, w_latch, w_hit, w_key;
    logic [ID_W-1:0]       w_ovl_id;
    logic [ADDR_W-1:0]     w_cell_addr, w_res_addr, w_dst_addr;

    assign w_last_px  = (r_px == PX_LAST) && (r_py == PX_LAST);
    assign w_last_col = (r_gx == CW'(MAP_W - 1));
    assign w_last_row = (r_gy == CW'(MAP_H - 1));
    assign w_latch    = ((r_state == S_IDLE) && start) ||
                        ((r_state == S_DONE) && ((CONTINUOUS != 0) || start));

    assign w_cell_addr = ADDR_W'(r_gy) * L_MAP_W + ADDR_W'(r_gx);
    assign w_res_addr  = ADDR_W'(r_id) * L_AREA + ADDR_W'(r_py) * L_TILE + ADDR_W'(r_px);
    assign w_dst_addr  = (ADDR_W'(r_gy) * L_TILE + ADDR_W'(r_py)) * L_FB_W
                       + ADDR_W'(r_gx) * L_TILE + ADDR_W'(r_px);

    // Descending scan so the lowest-index matching entity wins.
    always_comb begin
        w_hit    = 1'b0;
        w_ovl_id = '0;
        for (int i = N_OVL - 1; i >= 0; i--) begin
            if (r_sh_en[i] && (r_sh_x[i*CW +: CW] == r_gx) && (r_sh_y[i*CW +: CW] == r_gy)) begin
                w_hit    = 1'b1;
                w_ovl_id = r_sh_id[i*ID_W +: ID_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
            S_FETCH:   w_next = S_RESOLVE;
            S_RESOLVE: w_next = S_PIX;
            S_PIX:     if (w_last_px) w_next = (w_last_col && w_last_row) ? S_DONE : S_FETCH;
            S_DONE:    w_next = ((CONTINUOUS != 0) || start) ? S_FETCH : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_FETCH) || (r_state == S_RESOLVE) || (r_state == S_PIX);
        done     = (r_state == S_DONE);
        map_addr = w_cell_addr;
        res_addr = (r_state == S_PIX) ? w_res_addr : '0;
    end

    // Overlay shadows only change at a frame latch, so mid-frame input changes are invisible.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_sh_en <= ovl_en;
            r_sh_x  <= ovl_x;
            r_sh_y  <= ovl_y;
            r_sh_id <= ovl_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_gx  <= '0;
            r_gy  <= '0;
            r_px  <= '0;
            r_py  <= '0;
            r_id  <= '0;
            r_hit <= 1'b0;
        end else if (w_latch) begin
            r_gx <= '0;
            r_gy <= '0;
        end else if (r_state == S_RESOLVE) begin
            r_id  <= w_hit ? w_ovl_id : map_data;
            r_hit <= w_hit;
            r_px  <= '0;
            r_py  <= '0;
        end else if (r_state == S_PIX) begin
            if (r_px == PX_LAST) begin
                r_px <= '0;
                if (r_py == PX_LAST) begin
                    r_py <= '0;
                    if (w_last_col) begin
                        r_gx <= '0;
                        r_gy <= w_last_row ? '0 : r_gy + CW'(1);
                    end else begin
                        r_gx <= r_gx + CW'(1);
                    end
                end else begin
                    r_py <= r_py + PXW'(1);
                end
            end else begin
                r_px <= r_px + PXW'(1);
            end
        end
    end

    // p1: ROM data arrives; destination address and overlay flag delayed to match.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_vld_p1      <= 1'b0;
            r_hit_p1      <= 1'b0;
            r_dst_addr_p1 <= '0;
        end else begin
            r_vld_p1 <= (r_state == S_PIX);
            r_hit_p1 <= r_hit;
            if (r_state == S_PIX) r_dst_addr_p1 <= w_dst_addr;
        end
    end

    assign w_key    = (KEY_EN != 0) && r_hit_p1 && (res_data == KEY_COL);
    assign dst_addr = r_dst_addr_p1;
    assign dst_data = r_vld_p1 ? res_data : '0;
    assign dst_wr   = r_vld_p1 && !w_key;

endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
- Parametrised successor of the single-hero tile renderer.
- Walks a MAP_W x MAP_H tile grid. For each cell it reads the tile id from map RAM, substitutes the id of any enabled overlay entity (hero, monsters, items) at that cell, then copies that tile's TILE_PX x TILE_PX pixels from resource ROM into the VGA frame buffer.
- Adds a start/busy/done handshake, per-frame latching of overlay state, an optional transparent colour key and an optional free-running mode.

Parameters:
- MAP_W, 13, grid columns.
- MAP_H, 13, grid rows.
- TILE_PX, 32, tile edge in pixels (power of two).
- FB_W, 640, frame buffer line pitch in pixels.
- N_OVL, 4, number of overlay entities.
- CW, 4, width of one grid coordinate.
- ID_W, 16, tile id width.
- ADDR_W, 19, width of all RAM/ROM addresses.
- PIX_W, 16, pixel width.
- KEY_EN, 0, 1 = skip frame buffer writes of overlay pixels equal to KEY_COL.
- KEY_COL, 16'h0000, transparent colour.
- CONTINUOUS, 0, 1 = restart automatically after each frame.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  frame request, single-cycle pulse or level.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame end.
- ovl_en  in  N_OVL  per-entity enable.
- ovl_x  in  N_OVL*CW  entity grid x; entity i occupies [i*CW +: CW].
- ovl_y  in  N_OVL*CW  entity grid y.
- ovl_id  in  N_OVL*ID_W  entity tile id.
- map_addr  out  ADDR_W  map RAM address, equal to gy*MAP_W+gx.
- map_data  in  ID_W  map RAM data, valid 1 cycle after map_addr.
- res_addr  out  ADDR_W  resource ROM address.
- res_data  in  PIX_W  resource pixel, valid 1 cycle after res_addr.
- dst_addr  out  ADDR_W  frame buffer address.
- dst_data  out  PIX_W  frame buffer pixel.
- dst_wr  out  1  frame buffer write strobe.

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE; busy, done, dst_wr = 0; all address and data outputs = 0; grid and pixel counters = 0.
- Reset wins over every other input and aborts any frame in progress immediately. No further dst_wr is issued after the reset edge.
- State IDLE:
  - start=1 -> latch ovl_en/x/y/id into shadow registers; gx=gy=0; go to FETCH; busy=1 from the next cycle.
  - start is ignored while busy=1.
- State FETCH (1 cycle): drive map_addr = gy*MAP_W+gx; go to RESOLVE.
- State RESOLVE (1 cycle): select the tile id.
  - Lowest-index enabled shadow entity with x==gx and y==gy supplies its id and sets ovl_hit=1.
  - Otherwise the id is map_data and ovl_hit=0.
  - px=py=0; go to PIX.
- State PIX (TILE_PX*TILE_PX cycles, one pixel per cycle, px fastest):
  - res_addr = id*TILE_PX*TILE_PX + py*TILE_PX + px.
  - One cycle later: dst_wr=1, dst_data=res_data, dst_addr = (gy*TILE_PX+py)*FB_W + gx*TILE_PX + px (address pipelined to match).
  - When KEY_EN=1, ovl_hit=1 and res_data==KEY_COL: dst_wr=0 for that pixel; address and pixel counters still advance.
- Leaving PIX after the last pixel:
  - gx advances; gx wraps to 0 at MAP_W-1 and gy increments.
  - After cell (MAP_W-1, MAP_H-1) go to DONE; otherwise go to FETCH.
  - The last pixel's write completes in the first FETCH/DONE cycle.
- State DONE (1 cycle): done=1, busy=0. Go to IDLE; if CONTINUOUS=1 or start=1, re-latch the shadows and go directly to FETCH.
- Timing: per tile exactly TILE_PX^2+2 cycles. Frame = MAP_W*MAP_H*(TILE_PX^2+2) cycles from the first FETCH to DONE.
- Arithmetic:
  - All address products are computed at ADDR_W bits, unsigned, truncated modulo 2^ADDR_W with no saturation.
  - Overlays with coordinates >= MAP_W/MAP_H never match.
- Overlay inputs changing mid-frame have no effect until the next latch.

Test Plan:
- Small config MAP_W=2, MAP_H=2, TILE_PX=2, FB_W=4, map ids {0,1,2,3}, ROM pixel = address; pulse start.
  - Required: exactly 16 dst_wr; pixel at dst_addr a equals the expected ROM word.
  - Required: done pulses at cycle 24 after FETCH entry; busy high throughout.
- Overlay priority: entity 0 and entity 1 both at (1,0) with ids 5 and 6 -> tile (1,0) is sourced from id 5; with ovl_en[0]=0 it is sourced from id 6.
- Colour key: KEY_EN=1, KEY_COL=0, overlay tile containing two zero pixels.
  - Required: those 2 dst_wr are suppressed and the other 2 are written.
  - Required: a map tile with zero pixels has all pixels written.
- Start while busy: a pulse mid-frame is ignored. Changing ovl_x mid-frame leaves this frame unchanged; the change appears in the next frame.
- Reset mid-PIX: rstn=0 for one cycle -> dst_wr=0 and busy=0 on the next cycle, no done. A fresh start restarts the frame from cell (0,0).
- CONTINUOUS=1: after a single start, done pulses periodically every frame length + 1 cycles with no further start.
